mem_access_stage: RTL and testbench

//  MEM-stage data-memory access unit: sits between the EX/MEM register and the MEM/WB register.

---
 rtl/mips_mem_pkg.sv | 39 +++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_access_stage.sv | 146 ++++++++++++++
 tb/tb_mem_access_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage access unit: memop codes, FSM states,
// byte-enable patterns and access-size helpers.
package mips_mem_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_LO_H = 4'b0011;
  localparam logic [3:0] BE_HI_H = 4'b1100;
  localparam logic [3:0] BE_B0   = 4'b0001;

  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op_size(op))
      SZ_HALF: misaligned = a[0];
      SZ_WORD: misaligned = |a;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module mem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  memop_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (memop_i)
      OP_LB:   result_o = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  result_o = {24'h0, byte_v};
      OP_LH:   result_o = {{16{half_v[15]}}, half_v};
      OP_LHU:  result_o = {16'h0, half_v};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: one bus transaction per load/store,
// stalls the pipeline while busy, flags misalignment and bus timeouts.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  memopM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM,
  output logic        buserrM
);

  state_t      state_q, state_d;
  logic        req_q, we_q, ld_q, kill_q, berr_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  op_q;
  logic [1:0]  lo_q;
  logic [CNT_W-1:0] cnt_q;

  logic        is_idle, is_access, mis, start, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, align_res;

  assign is_idle   = (state_q == IDLE);
  assign is_access = MemReadM | MemWriteM;
  assign mis       = misaligned(memopM, aluoutM[1:0]);
  assign start     = is_idle & is_access & ~mis & ~flush;
  assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  assign adelM   = is_idle & MemReadM & ~MemWriteM & mis;
  assign adesM   = is_idle & MemWriteM & mis;
  assign stallM  = start | (state_q == BUSY);
  assign buserrM = (state_q == DONE) & berr_q & ~kill_q;

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign readdataM = rdata_q;

  // Store lane steering; a read is always a full-word fetch, extraction happens later
  always_comb begin
    be_d    = BE_ALL;
    wdata_d = writedataM;
    if (MemWriteM) begin
      case (op_size(memopM))
        SZ_BYTE: begin
          be_d    = BE_B0 << aluoutM[1:0];
          wdata_d = {4{writedataM[7:0]}};
        end
        SZ_HALF: begin
          be_d    = aluoutM[1] ? BE_HI_H : BE_LO_H;
          wdata_d = {2{writedataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (mem_ack || timeout) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  mem_load_align u_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (lo_q),
    .memop_i   (op_q),
    .result_o  (align_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      kill_q  <= 1'b0;
      berr_q  <= 1'b0;
      ld_q    <= 1'b0;
      op_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          req_q   <= 1'b1;
          we_q    <= MemWriteM;
          ld_q    <= ~MemWriteM;
          be_q    <= be_d;
          addr_q  <= {aluoutM[31:2], 2'b00};
          wdata_q <= wdata_d;
          op_q    <= memopM;
          lo_q    <= aluoutM[1:0];
          cnt_q   <= '0;
        end
        BUSY: begin
          // A flushed instruction still finishes its bus cycle but delivers nothing
          kill_q <= kill_q | flush;
          cnt_q  <= cnt_q + 1'b1;
          if (mem_ack) begin
            req_q   <= 1'b0;
            rdata_q <= (ld_q && !kill_q && !flush) ? align_res : 32'h0;
          end else if (timeout) begin
            req_q   <= 1'b0;
            berr_q  <= 1'b1;
            rdata_q <= 32'h0;
          end
        end
        default: begin
          kill_q <= 1'b0;
          berr_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table of single accesses plus
// hand-written timeout, flush, reset and ignored-ack sequences.
module tb_mem_access_stage;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, MemReadM, MemWriteM, mem_ack;
  logic [2:0]  memopM;
  logic [31:0] aluoutM, writedataM, mem_rdata;
  logic        mem_req, mem_we, stallM, adelM, adesM, buserrM;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, readdataM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .memopM(memopM),
    .aluoutM(aluoutM), .writedataM(writedataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .readdataM(readdataM), .stallM(stallM),
    .adelM(adelM), .adesM(adesM), .buserrM(buserrM)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  op;
    logic [31:0] addr, wd, rdata;
    int          ack_dly;
    logic [3:0]  be;
    logic [31:0] maddr, mwd;
    logic        chk_wd;
    logic [31:0] rdm;
    int          stalls;
    logic        adel, ades;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    MemReadM = 0; MemWriteM = 0; flush = 0; mem_ack = 0;
  endtask

  // Runs BUSY cycles until the stall drops; counts stalled cycles seen.
  task automatic run_busy(input int ack_at, input int flush_at, input logic [31:0] rd,
                          output int stalls);
    logic done;
    done = 0;
    stalls = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (stallM) stalls++;
      flush = (k == flush_at);
      mem_ack = (k == ack_at);
      mem_rdata = rd;
      @(posedge clk); #1;
      flush = 0; mem_ack = 0;
      if (!stallM) done = 1;
    end
    if (!done) chk("busy_bound", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int s0, sb;
    @(negedge clk);
    MemReadM = v.rd; MemWriteM = v.wr; memopM = v.op;
    aluoutM = v.addr; writedataM = v.wd; mem_ack = 0;
    #1;
    chk($sformatf("v%0d adelM", idx), {31'b0, adelM}, {31'b0, v.adel});
    chk($sformatf("v%0d adesM", idx), {31'b0, adesM}, {31'b0, v.ades});
    if (v.adel || v.ades) begin
      chk($sformatf("v%0d mis_stall", idx), {31'b0, stallM}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d mis_req", idx), {31'b0, mem_req}, 32'd0);
      clear_in();
    end else begin
      s0 = stallM ? 1 : 0;
      @(posedge clk); #1;
      chk($sformatf("v%0d req", idx), {31'b0, mem_req}, 32'd1);
      chk($sformatf("v%0d we", idx), {31'b0, mem_we}, {31'b0, v.wr});
      chk($sformatf("v%0d be", idx), {28'b0, mem_be}, {28'b0, v.be});
      chk($sformatf("v%0d addr", idx), mem_addr, v.maddr);
      if (v.chk_wd) chk($sformatf("v%0d wdata", idx), mem_wdata, v.mwd);
      run_busy(v.ack_dly, -1, v.rdata, sb);
      chk($sformatf("v%0d stalls", idx), s0 + sb, v.stalls);
      chk($sformatf("v%0d readdata", idx), readdataM, v.rdm);
      chk($sformatf("v%0d buserr", idx), {31'b0, buserrM}, 32'd0);
      chk($sformatf("v%0d req_drop", idx), {31'b0, mem_req}, 32'd0);
      clear_in();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, s0, sb;
    //            rd wr op      addr         wd            rdata       dly be       maddr        mwd          cw rdm          st adel ades
    vecs[0]  = '{1, 0, OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h100, 32'h0,        0, 32'hDEADBEEF, 2, 0, 0};
    vecs[1]  = '{1, 0, OP_LB,  32'h103, 32'h0,        32'h80123456, 0, 4'b1111, 32'h100, 32'h0,        0, 32'hFFFFFF80, 2, 0, 0};
    vecs[2]  = '{1, 0, OP_LBU, 32'h103, 32'h0,        32'h80123456, 0, 4'b1111, 32'h100, 32'h0,        0, 32'h00000080, 2, 0, 0};
    vecs[3]  = '{1, 0, OP_LH,  32'h102, 32'h0,        32'h80123456, 0, 4'b1111, 32'h100, 32'h0,        0, 32'hFFFF8012, 2, 0, 0};
    vecs[4]  = '{1, 0, OP_LHU, 32'h102, 32'h0,        32'h80123456, 0, 4'b1111, 32'h100, 32'h0,        0, 32'h00008012, 2, 0, 0};
    vecs[5]  = '{1, 0, OP_LH,  32'h100, 32'h0,        32'h1234F00D, 2, 4'b1111, 32'h100, 32'h0,        0, 32'hFFFFF00D, 4, 0, 0};
    vecs[6]  = '{0, 1, OP_SB,  32'h007, 32'h123456AB, 32'h0,        0, 4'b1000, 32'h004, 32'hABABABAB, 1, 32'h0,        2, 0, 0};
    vecs[7]  = '{0, 1, OP_SH,  32'h202, 32'hCAFEBEEF, 32'h0,        0, 4'b1100, 32'h200, 32'hBEEFBEEF, 1, 32'h0,        2, 0, 0};
    vecs[8]  = '{0, 1, OP_SW,  32'h300, 32'h01234567, 32'h0,        1, 4'b1111, 32'h300, 32'h01234567, 1, 32'h0,        3, 0, 0};
    vecs[9]  = '{1, 0, OP_LW,  32'h102, 32'h0,        32'h0,        0, 4'b0000, 32'h0,   32'h0,        0, 32'h0,        0, 1, 0};
    vecs[10] = '{0, 1, OP_SH,  32'h001, 32'h0,        32'h0,        0, 4'b0000, 32'h0,   32'h0,        0, 32'h0,        0, 0, 1};
    vecs[11] = '{1, 0, OP_LBU, 32'h101, 32'h0,        32'h11223344, 0, 4'b1111, 32'h100, 32'h0,        0, 32'h00000033, 2, 0, 0};
    vecs[12] = '{1, 0, OP_LB,  32'h102, 32'h0,        32'h11F23344, 0, 4'b1111, 32'h100, 32'h0,        0, 32'hFFFFFFF2, 2, 0, 0};
    vecs[13] = '{1, 0, OP_LH,  32'h003, 32'h0,        32'h0,        0, 4'b0000, 32'h0,   32'h0,        0, 32'h0,        0, 1, 0};
    vecs[14] = '{1, 1, OP_SW,  32'h002, 32'h0,        32'h0,        0, 4'b0000, 32'h0,   32'h0,        0, 32'h0,        0, 0, 1};

    reset = 1; clear_in(); memopM = OP_LW; aluoutM = 0; writedataM = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0; #1;
    chk("rst mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst readdataM", readdataM, 32'd0);
    chk("rst flags", {28'b0, stallM, adelM, adesM, buserrM}, 32'd0);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Timeout: no ack, 5 BUSY cycles then DONE with buserr pulse
    @(negedge clk);
    MemReadM = 1; memopM = OP_LW; aluoutM = 32'h40;
    @(posedge clk); #1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
    chk("to busy_cycles", n, 5);
    chk("to buserr", {31'b0, buserrM}, 32'd1);
    chk("to stall_done", {31'b0, stallM}, 32'd0);
    clear_in();
    @(negedge clk);
    chk("to buserr_pulse", {31'b0, buserrM}, 32'd0);

    // Flush in BUSY, ack three cycles later: data killed, no bus error
    @(negedge clk);
    MemReadM = 1; memopM = OP_LW; aluoutM = 32'h80; #1;
    s0 = stallM ? 1 : 0;
    @(posedge clk); #1;
    run_busy(3, 0, 32'hDEADBEEF, sb);
    chk("fl stalls", s0 + sb, 5);
    chk("fl readdata", readdataM, 32'd0);
    chk("fl buserr", {31'b0, buserrM}, 32'd0);
    clear_in();
    @(posedge clk); #1;

    // Flush followed by timeout: bus error suppressed
    @(negedge clk);
    MemReadM = 1; memopM = OP_LW; aluoutM = 32'hC0; #1;
    s0 = stallM ? 1 : 0;
    @(posedge clk); #1;
    run_busy(-1, 1, 32'h0, sb);
    chk("flto stalls", s0 + sb, 6);
    chk("flto buserr", {31'b0, buserrM}, 32'd0);
    clear_in();
    @(posedge clk); #1;

    // Flush while IDLE: no request
    @(negedge clk);
    MemWriteM = 1; memopM = OP_SW; aluoutM = 32'h10; flush = 1; #1;
    chk("flidle stall", {31'b0, stallM}, 32'd0);
    @(posedge clk); #1;
    chk("flidle req", {31'b0, mem_req}, 32'd0);
    clear_in();

    // Ack while IDLE is ignored
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h55AA55AA; #1;
    chk("ackidle stall", {31'b0, stallM}, 32'd0);
    @(posedge clk); #1;
    chk("ackidle req", {31'b0, mem_req}, 32'd0);
    chk("ackidle readdata", readdataM, 32'd0);
    mem_ack = 0;

    // Reset mid-BUSY aborts the request
    @(negedge clk);
    MemReadM = 1; memopM = OP_LW; aluoutM = 32'h200;
    @(posedge clk); #1;
    chk("rstbusy req_on", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    reset = 1; clear_in();
    @(posedge clk); #1;
    chk("rstbusy req", {31'b0, mem_req}, 32'd0);
    chk("rstbusy stall", {31'b0, stallM}, 32'd0);
    reset = 0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
